// File: rtl/pc_fetch_sequencer_pkg.sv
// Shared encodings for the fetch sequencer: PC mux selects and FSM states.
package pc_fetch_sequencer_pkg;

  localparam logic [1:0] SEL_SEQ  = 2'd0;
  localparam logic [1:0] SEL_BR   = 2'd1;
  localparam logic [1:0] SEL_JMP  = 2'd2;
  localparam logic [1:0] SEL_HOLD = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_ISSUE = 2'd2,
    ST_ERR   = 2'd3
  } state_e;

  // A taken branch outranks a jump resolved in the same cycle.
  function automatic logic [1:0] redirect_sel(input logic br_taken);
    return br_taken ? SEL_BR : SEL_JMP;
  endfunction

endpackage

// File: rtl/pc_fetch_sequencer_wait_timer.sv
// Saturating memory-wait counter; expire_o is combinational and flags the increment that reaches all-ones.
// Clear takes priority over increment; no backpressure.
module fetch_wait_timer #(
  parameter int WAIT_W = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic inc_i,
  output logic expire_o
);

  localparam logic [WAIT_W-1:0] CNT_MAX = '1;

  logic [WAIT_W-1:0] cnt_q;
  logic [WAIT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign expire_o = inc_i & ~clr_i & (cnt_q == (CNT_MAX - 1'b1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Fetch controller: drives the PC mux select, imem req/ack and decode valid/ready; pc_sel/flush are same-cycle.
// Decode backpressure (ready low or stall) holds the offered instruction and the PC.
module pc_fetch_sequencer
  import pc_fetch_sequencer_pkg::*;
#(
  parameter int WAIT_W = 4
) (
  input  logic       clk,
  input  logic       reset,
  output logic       imem_req,
  input  logic       imem_ack,
  output logic       instr_valid,
  input  logic       decode_ready,
  input  logic       stall,
  input  logic       branch_valid,
  input  logic       branch_taken,
  input  logic       jump_valid,
  output logic [1:0] pc_sel,
  output logic       flush,
  output logic       imem_err
);

  state_e state_q;
  state_e state_d;
  logic   drop_q;
  logic   drop_d;
  logic   br_take;
  logic   redirect;
  logic   tmr_clr;
  logic   tmr_inc;
  logic   expire;

  assign br_take  = branch_valid & branch_taken;
  assign redirect = br_take | jump_valid;

  assign tmr_inc = (state_q == ST_REQ) & ~imem_ack;
  assign tmr_clr = (state_q != ST_REQ) | imem_ack;

  fetch_wait_timer #(
    .WAIT_W(WAIT_W)
  ) u_wait_timer (
    .clk     (clk),
    .rst_n   (reset),
    .clr_i   (tmr_clr),
    .inc_i   (tmr_inc),
    .expire_o(expire)
  );

  always_comb begin
    state_d = state_q;
    drop_d  = drop_q;
    pc_sel  = SEL_HOLD;
    flush   = 1'b0;

    if ((state_q != ST_ERR) && redirect) begin
      pc_sel = redirect_sel(br_take);
      flush  = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        state_d = ST_REQ;
        drop_d  = 1'b0;
      end
      ST_REQ: begin
        if (imem_ack) begin
          // Response for a stale PC is dropped; req stays up as the new PC's request.
          drop_d = 1'b0;
          if (!drop_q && !redirect) begin
            state_d = ST_ISSUE;
          end
        end else begin
          if (redirect) begin
            drop_d = 1'b1;
          end
          if (expire) begin
            state_d = ST_ERR;
          end
        end
      end
      ST_ISSUE: begin
        if (redirect) begin
          state_d = ST_REQ;
        end else if (decode_ready && !stall) begin
          pc_sel  = SEL_SEQ;
          state_d = ST_REQ;
        end
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (!reset) begin
      pc_sel = SEL_HOLD;
      flush  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
    end
  end

  assign imem_req    = (state_q == ST_REQ);
  assign instr_valid = (state_q == ST_ISSUE);
  assign imem_err    = (state_q == ST_ERR);

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed cycle-by-cycle stimulus; each cycle's expected outputs are queued and checked by a separate monitor.
module tb_pc_fetch_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       imem_req;
  logic       imem_ack;
  logic       instr_valid;
  logic       decode_ready;
  logic       stall;
  logic       branch_valid;
  logic       branch_taken;
  logic       jump_valid;
  logic [1:0] pc_sel;
  logic       flush;
  logic       imem_err;

  typedef struct {
    logic [5:0] v;  // {req, valid, sel[1:0], flush, err}
    string      nm;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  pc_fetch_sequencer #(.WAIT_W(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_ack    (imem_ack),
    .instr_valid (instr_valid),
    .decode_ready(decode_ready),
    .stall       (stall),
    .branch_valid(branch_valid),
    .branch_taken(branch_taken),
    .jump_valid  (jump_valid),
    .pc_sel      (pc_sel),
    .flush       (flush),
    .imem_err    (imem_err)
  );

  // Monitor: one expectation per driven cycle, sampled on the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t       e;
      logic [5:0] got;
      e   = exp_q.pop_front();
      got = {imem_req, instr_valid, pc_sel, flush, imem_err};
      checks++;
      if (got !== e.v) begin
        failures++;
        $display("FAIL %s got req/val/sel/flush/err=%b expected=%b", e.nm, got, e.v);
      end
    end
  end

  // Drive one cycle of inputs, queue the outputs expected during it, advance to the next cycle.
  task automatic step(input logic ack, input logic rdy, input logic stl,
                      input logic bv, input logic bt, input logic jv,
                      input logic e_req, input logic e_val, input logic [1:0] e_sel,
                      input logic e_fl, input logic e_err, input string nm);
    exp_t e;
    imem_ack     = ack;
    decode_ready = rdy;
    stall        = stl;
    branch_valid = bv;
    branch_taken = bt;
    jump_valid   = jv;
    e.v  = {e_req, e_val, e_sel, e_fl, e_err};
    e.nm = nm;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end of stimulus");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    imem_ack = 0; decode_ready = 0; stall = 0;
    branch_valid = 0; branch_taken = 0; jump_valid = 0;
    @(posedge clk);
    #1;

    //    ack rdy stl bv bt jv   req val sel   fl err
    step(0, 0, 0, 0, 0, 0,   0, 0, 2'd3, 0, 0, "reset_state");
    step(0, 0, 0, 1, 1, 1,   0, 0, 2'd3, 0, 0, "reset_masks_redirect");

    // Basic fetch: ack on third req cycle, immediate accept.
    reset = 1'b1;
    step(0, 0, 0, 0, 0, 0,   0, 0, 2'd3, 0, 0, "idle_after_release");
    step(0, 0, 0, 0, 0, 0,   1, 0, 2'd3, 0, 0, "req_wait1");
    step(0, 0, 0, 0, 0, 0,   1, 0, 2'd3, 0, 0, "req_wait2");
    step(1, 0, 0, 0, 0, 0,   1, 0, 2'd3, 0, 0, "req_ack");
    step(0, 1, 0, 0, 0, 0,   0, 1, 2'd0, 0, 0, "issue_accept_seq");

    // Backpressure: not-ready then two stalled cycles hold the instruction.
    step(1, 0, 0, 0, 0, 0,   1, 0, 2'd3, 0, 0, "req_ack_fast");
    step(0, 0, 0, 0, 0, 0,   0, 1, 2'd3, 0, 0, "issue_not_ready");
    step(0, 1, 1, 0, 0, 0,   0, 1, 2'd3, 0, 0, "issue_stall1");
    step(0, 1, 1, 0, 0, 0,   0, 1, 2'd3, 0, 0, "issue_stall2");
    step(0, 1, 0, 0, 0, 0,   0, 1, 2'd0, 0, 0, "issue_unstalled_accept");

    // Taken branch one cycle before ack: that ack is dropped, the next one issues.
    step(0, 0, 0, 1, 1, 0,   1, 0, 2'd1, 1, 0, "req_branch_redirect");
    step(1, 0, 0, 0, 0, 0,   1, 0, 2'd3, 0, 0, "req_ack_dropped");
    step(0, 0, 0, 0, 0, 0,   1, 0, 2'd3, 0, 0, "req_still_high");
    step(1, 0, 0, 0, 0, 0,   1, 0, 2'd3, 0, 0, "req_ack_new_pc");
    step(0, 1, 0, 1, 1, 1,   0, 1, 2'd1, 1, 0, "issue_branch_beats_jump");

    // Untaken branch is not a redirect.
    step(0, 0, 0, 0, 0, 0,   1, 0, 2'd3, 0, 0, "req_after_issue_redirect");
    step(1, 0, 0, 0, 0, 0,   1, 0, 2'd3, 0, 0, "req_ack_b");
    step(0, 1, 0, 1, 0, 0,   0, 1, 2'd0, 0, 0, "issue_untaken_branch");

    // Jump in ISSUE without accept, then jump coinciding with ack in REQ.
    step(1, 0, 0, 0, 0, 0,   1, 0, 2'd3, 0, 0, "req_ack_c");
    step(0, 0, 0, 0, 0, 1,   0, 1, 2'd2, 1, 0, "issue_jump");
    step(1, 0, 0, 0, 0, 1,   1, 0, 2'd2, 1, 0, "req_ack_with_jump");
    step(1, 0, 0, 0, 0, 0,   1, 0, 2'd3, 0, 0, "req_ack_after_same_cycle_drop");
    step(0, 1, 0, 0, 0, 0,   0, 1, 2'd0, 0, 0, "issue_accept_d");

    // Timeout: 15 req cycles without ack, error from the 16th.
    for (int i = 1; i <= 15; i++) begin
      step(0, 0, 0, 0, 0, 0, 1, 0, 2'd3, 0, 0, $sformatf("timeout_wait%0d", i));
    end
    step(0, 0, 0, 0, 0, 0,   0, 0, 2'd3, 0, 1, "err_entered");
    step(1, 1, 0, 1, 1, 1,   0, 0, 2'd3, 0, 1, "err_ignores_redirect");
    step(0, 0, 0, 0, 0, 0,   0, 0, 2'd3, 0, 1, "err_sticky");

    // Reset clears error; reset mid-REQ also clears a pending drop.
    reset = 1'b0;
    step(0, 0, 0, 0, 0, 0,   0, 0, 2'd3, 0, 0, "reset_clears_err");
    reset = 1'b1;
    step(0, 0, 0, 0, 0, 0,   0, 0, 2'd3, 0, 0, "idle_after_release2");
    step(0, 0, 0, 1, 1, 0,   1, 0, 2'd1, 1, 0, "req_branch_sets_drop");
    reset = 1'b0;
    step(0, 0, 0, 0, 0, 0,   0, 0, 2'd3, 0, 0, "reset_mid_req");
    reset = 1'b1;
    step(0, 0, 0, 0, 0, 0,   0, 0, 2'd3, 0, 0, "idle_after_release3");
    step(1, 0, 0, 0, 0, 0,   1, 0, 2'd3, 0, 0, "req_ack_drop_cleared");
    step(0, 1, 0, 0, 0, 0,   0, 1, 2'd0, 0, 0, "issue_after_drop_cleared");
    step(0, 0, 0, 0, 0, 0,   1, 0, 2'd3, 0, 0, "req_final");

    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d leftover expected=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
- Multi-cycle fetch controller for the program-counter datapath.
- Drives the 2-bit next-PC select of the PC 4:1 mux:
  - 0 = PC+1
  - 1 = branch target
  - 2 = jump target
  - 3 = current PC (hold)
- Handshakes with instruction memory (req/ack) and decode (valid/ready).
- Applies branch/jump redirects, kills in-flight or offered instructions, and flags memory timeouts.

Parameters:
- WAIT_W, 4, width of the memory-wait counter; timeout after 2^WAIT_W-1 cycles of req without ack.

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset
- imem_req  output  1  fetch request for the current PC; held until imem_ack
- imem_ack  input  1  one-cycle pulse: instruction for the current request is available
- instr_valid  output  1  fetched instruction offered to decode
- decode_ready  input  1  decode can accept this cycle
- stall  input  1  hazard stall; blocks acceptance and PC advance
- branch_valid  input  1  branch resolved this cycle
- branch_taken  input  1  qualifies branch_valid
- jump_valid  input  1  jump resolved this cycle
- pc_sel  output  2  next-PC select to the PC mux
- flush  output  1  one-cycle pulse on redirect; decode discards anything accepted this cycle
- imem_err  output  1  sticky memory-timeout error

Behaviour:
- States: IDLE, REQ, ISSUE, ERR. State register, wait counter and drop flag are async-cleared by reset=0.
- Reset values: state=IDLE, imem_req=0, instr_valid=0, flush=0, imem_err=0, drop=0, counter=0. pc_sel=3 while reset=0.
- imem_req=1 exactly in REQ; instr_valid=1 exactly in ISSUE (Moore outputs).
- pc_sel is combinational (Mealy). Default is 3; PC changes only on the edge where pc_sel!=3.
- redirect = (branch_valid & branch_taken) | jump_valid. Branch has priority over jump. Redirect is honoured in IDLE, REQ and ISSUE and ignored in ERR.
- On a redirect cycle:
  - pc_sel = 1 if a branch is taken, else 2.
  - flush=1 for that cycle only.
- IDLE: one cycle after reset release, then REQ. pc_sel=3 unless a redirect occurs.
- REQ:
  - Counter increments each cycle without ack.
  - ack & !drop & !redirect -> ISSUE; counter cleared.
  - ack & (drop | redirect) -> data discarded, stay REQ, drop cleared, counter cleared. imem_req stays 1 and is treated as a new request for the new PC.
  - redirect without ack -> drop=1, stay REQ; the outstanding response will be discarded.
  - Counter reaches 2^WAIT_W-1 without ack -> ERR, imem_err=1.
- ISSUE:
  - decode_ready & !stall & !redirect -> pc_sel=0 (PC+1), go to REQ.
  - redirect -> pc_sel per redirect, instr_valid drops next cycle, go to REQ. Redirect wins over a simultaneous accept; flush kills the accepted instruction.
  - stall or !decode_ready -> hold; pc_sel=3, instr_valid stays 1.
- ERR: pc_sel=3, imem_req=0, instr_valid=0, imem_err=1. Left only by reset.
- Reset asserted mid-operation immediately forces the reset values, including any pending drop.
- Counter saturates; it does not wrap.

Decomposition:
- Shared package holds:
  - pc_sel encodings SEL_SEQ=0, SEL_BR=1, SEL_JMP=2, SEL_HOLD=3.
  - FSM state encoding.
- One sub-module is natural: fetch_wait_timer (counter with clear, increment and saturate, plus timeout flag), instantiated with WAIT_W.

Test Plan:
- Reset release, imem_ack 3 cycles after req, decode_ready=1 -> IDLE 1 cycle, req high 3 cycles, instr_valid 1 cycle, pc_sel=0 on the accept cycle, 3 otherwise.
- Decode accepts with stall=1 for 2 cycles -> instr_valid held 2 extra cycles with pc_sel=3; pc_sel=0 on the first unstalled cycle.
- branch_valid=branch_taken=1 in REQ 1 cycle before ack -> pc_sel=1, flush=1 for one cycle. Next ack is discarded (instr_valid stays 0), req remains high, the following ack leads to ISSUE.
- branch_taken and jump_valid together in ISSUE with decode_ready=1 -> pc_sel=1 (not 2), flush=1, next state REQ.
- branch_valid=1, branch_taken=0 in ISSUE -> no flush, normal accept with pc_sel=0.
- No ack for 15 cycles (WAIT_W=4) -> imem_err=1, req=0 from cycle 16. Redirect in ERR is ignored; reset=0 clears everything.
